mem_port_arbiter: RTL and testbench

- Shares one unified 16-bit memory backend between the pipeline's instruction-fetch port (read-only) and data port (read/write).
- Replaces the separate instruction and data memories. Per-port done pulses stall the IF stage and the MEM stage until their access completes.
- Data has fixed priority. A streak limit guarantees instruction fetch forward progress.

---
 rtl/mem_port_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one memory backend between the instruction-fetch (read-only) and data ports; data has fixed priority.
// A grant costs one edge, the access waits for m_ack, then one DONE cycle follows; a held request is re-arbitrated after DONE.
module mem_port_arbiter #(
  parameter int WORD_SIZE    = 16,
  parameter int MAX_D_STREAK = 3
) (
  input  logic                 Clk,
  input  logic                 Reset_N,
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_addr,
  output logic [WORD_SIZE-1:0] i_rdata,
  output logic                 i_done,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 d_done,
  output logic                 m_req,
  output logic                 m_we,
  output logic [WORD_SIZE-1:0] m_addr,
  output logic [WORD_SIZE-1:0] m_wdata,
  input  logic [WORD_SIZE-1:0] m_rdata,
  input  logic                 m_ack,
  output logic                 busy,
  output logic                 grant_d
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] LP_MAX_STREAK = 4'(MAX_D_STREAK);

  state_t     r_state;
  logic [3:0] r_streak;

  logic       w_any_req;
  logic       w_pick_d;
  logic [3:0] w_streak_nxt;

  assign w_any_req = i_req | d_req;

  // Data wins unless instruction fetch has already been passed over MAX_D_STREAK times in a row.
  assign w_pick_d = d_req & (~i_req | (r_streak < LP_MAX_STREAK));

  // The streak only counts data grants that actually made a waiting fetch wait.
  always_comb begin
    w_streak_nxt = 4'd0;
    if (w_pick_d && i_req) begin
      w_streak_nxt = (r_streak == 4'hF) ? r_streak : r_streak + 4'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_N) begin
      r_state  <= S_IDLE;
      r_streak <= 4'd0;
      m_req    <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      i_done   <= 1'b0;
      d_done   <= 1'b0;
      i_rdata  <= '0;
      d_rdata  <= '0;
      busy     <= 1'b0;
      grant_d  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_state  <= S_BUSY;
            r_streak <= w_streak_nxt;
            m_req    <= 1'b1;
            busy     <= 1'b1;
            grant_d  <= w_pick_d;
            if (w_pick_d) begin
              m_addr  <= d_addr;
              m_we    <= d_we;
              m_wdata <= d_wdata;
            end else begin
              m_addr  <= i_addr;
              m_we    <= 1'b0;
            end
          end
        end

        S_BUSY: begin
          if (m_ack) begin
            r_state <= S_DONE;
            m_req   <= 1'b0;
            m_we    <= 1'b0;
            if (grant_d) begin
              d_done <= 1'b1;
              // Writes leave the last read result visible to the MEM stage.
              if (!m_we) begin
                d_rdata <= m_rdata;
              end
            end else begin
              i_done  <= 1'b1;
              i_rdata <= m_rdata;
            end
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          i_done  <= 1'b0;
          d_done  <= 1'b0;
          busy    <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: each step drives inputs, advances one edge and checks registered outputs.
module tb_mem_port_arbiter;

  logic        Clk;
  logic        Reset_N;
  logic        i_req;
  logic [15:0] i_addr;
  logic [15:0] i_rdata;
  logic        i_done;
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic [15:0] d_rdata;
  logic        d_done;
  logic        m_req;
  logic        m_we;
  logic [15:0] m_addr;
  logic [15:0] m_wdata;
  logic [15:0] m_rdata;
  logic        m_ack;
  logic        busy;
  logic        grant_d;

  int total;
  int bad;

  mem_port_arbiter #(
    .WORD_SIZE   (16),
    .MAX_D_STREAK(3)
  ) dut (
    .Clk    (Clk),
    .Reset_N(Reset_N),
    .i_req  (i_req),
    .i_addr (i_addr),
    .i_rdata(i_rdata),
    .i_done (i_done),
    .d_req  (d_req),
    .d_we   (d_we),
    .d_addr (d_addr),
    .d_wdata(d_wdata),
    .d_rdata(d_rdata),
    .d_done (d_done),
    .m_req  (m_req),
    .m_we   (m_we),
    .m_addr (m_addr),
    .m_wdata(m_wdata),
    .m_rdata(m_rdata),
    .m_ack  (m_ack),
    .busy   (busy),
    .grant_d(grant_d)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Backend completes the access on the next edge with the given read data.
  task automatic ack(input logic [15:0] data);
    m_rdata = data;
    m_ack   = 1'b1;
    step();
    m_ack   = 1'b0;
  endtask

  logic        exp_d_seq [8];
  logic [15:0] exp_addr;

  initial begin
    total     = 0;
    bad       = 0;
    exp_d_seq = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    Reset_N   = 1'b0;
    i_req     = 1'b0;
    i_addr    = 16'h0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    d_addr    = 16'h0;
    d_wdata   = 16'h0;
    m_rdata   = 16'h0;
    m_ack     = 1'b0;
    step();
    step();

    chk("rst_m_req",   {15'd0, m_req},   16'd0);
    chk("rst_busy",    {15'd0, busy},    16'd0);
    chk("rst_grant_d", {15'd0, grant_d}, 16'd0);
    chk("rst_i_done",  {15'd0, i_done},  16'd0);
    chk("rst_m_addr",  m_addr,           16'h0);
    chk("rst_i_rdata", i_rdata,          16'h0);
    Reset_N = 1'b1;
    step();

    // Single instruction read, ack two cycles after m_req.
    i_req  = 1'b1;
    i_addr = 16'h0010;
    step();
    chk("if_m_req",   {15'd0, m_req},   16'd1);
    chk("if_m_addr",  m_addr,           16'h0010);
    chk("if_m_we",    {15'd0, m_we},    16'd0);
    chk("if_grant_d", {15'd0, grant_d}, 16'd0);
    chk("if_busy",    {15'd0, busy},    16'd1);
    step();
    chk("if_wait_done", {15'd0, i_done}, 16'd0);
    ack(16'hA5A5);
    chk("if_i_done",  {15'd0, i_done}, 16'd1);
    chk("if_d_done",  {15'd0, d_done}, 16'd0);
    chk("if_i_rdata", i_rdata,         16'hA5A5);
    chk("if_m_req_lo",{15'd0, m_req},  16'd0);
    i_req = 1'b0;
    step();
    chk("if_done_lo", {15'd0, i_done}, 16'd0);
    chk("if_idle",    {15'd0, busy},   16'd0);

    // Data write: d_rdata must not pick up the bus value.
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 16'h0040;
    d_wdata = 16'h1234;
    step();
    chk("wr_m_we",    {15'd0, m_we},    16'd1);
    chk("wr_m_wdata", m_wdata,          16'h1234);
    chk("wr_m_addr",  m_addr,           16'h0040);
    chk("wr_grant_d", {15'd0, grant_d}, 16'd1);
    step();
    ack(16'hFFFF);
    chk("wr_d_done",  {15'd0, d_done}, 16'd1);
    chk("wr_d_rdata", d_rdata,         16'h0000);
    d_req = 1'b0;
    step();
    chk("wr_done_lo", {15'd0, d_done}, 16'd0);

    // Data read of the same word, backend latency 1.
    d_req = 1'b1;
    d_we  = 1'b0;
    step();
    chk("rd_m_we", {15'd0, m_we}, 16'd0);
    ack(16'h1234);
    chk("rd_d_done",  {15'd0, d_done}, 16'd1);
    chk("rd_d_rdata", d_rdata,         16'h1234);
    chk("rd_i_hold",  i_rdata,         16'hA5A5);
    d_req = 1'b0;
    step();

    // Both ports held high: D,D,D,I repeating.
    i_req  = 1'b1;
    i_addr = 16'h0100;
    d_req  = 1'b1;
    d_addr = 16'h0200;
    for (int k = 0; k < 8; k++) begin
      step();
      exp_addr = exp_d_seq[k] ? 16'h0200 : 16'h0100;
      chk($sformatf("arb%0d_grant_d", k), {15'd0, grant_d}, {15'd0, exp_d_seq[k]});
      chk($sformatf("arb%0d_m_addr", k),  m_addr,           exp_addr);
      ack(16'h0F00 + 16'(k));
      chk($sformatf("arb%0d_d_done", k), {15'd0, d_done}, {15'd0, exp_d_seq[k]});
      chk($sformatf("arb%0d_i_done", k), {15'd0, i_done}, {15'd0, ~exp_d_seq[k]});
      step();
      chk($sformatf("arb%0d_idle", k), {15'd0, busy}, 16'd0);
    end
    chk("arb_i_rdata", i_rdata, 16'h0F07);
    chk("arb_d_rdata", d_rdata, 16'h0F06);
    i_req = 1'b0;
    d_req = 1'b0;
    step();

    // d_req held through DONE with a new address: no grant during DONE, one exactly after.
    d_req  = 1'b1;
    d_addr = 16'h0300;
    step();
    chk("b2b_m_addr0", m_addr, 16'h0300);
    ack(16'h5555);
    chk("b2b_d_done0", {15'd0, d_done}, 16'd1);
    d_addr = 16'h0304;
    step();
    chk("b2b_no_dup_req",  {15'd0, m_req}, 16'd0);
    chk("b2b_no_dup_busy", {15'd0, busy},  16'd0);
    step();
    chk("b2b_m_req1",  {15'd0, m_req}, 16'd1);
    chk("b2b_m_addr1", m_addr,         16'h0304);
    d_addr = 16'hBEEF;
    step();
    chk("b2b_addr_stable", m_addr, 16'h0304);
    ack(16'h6666);
    chk("b2b_d_rdata", d_rdata, 16'h6666);
    d_req = 1'b0;
    step();

    // Reset in the middle of an instruction access.
    i_req  = 1'b1;
    i_addr = 16'h0020;
    step();
    chk("rmb_m_req_hi", {15'd0, m_req}, 16'd1);
    i_req   = 1'b0;
    Reset_N = 1'b0;
    step();
    chk("rmb_m_req",   {15'd0, m_req},  16'd0);
    chk("rmb_busy",    {15'd0, busy},   16'd0);
    chk("rmb_i_done",  {15'd0, i_done}, 16'd0);
    chk("rmb_i_rdata", i_rdata,         16'h0000);
    chk("rmb_d_rdata", d_rdata,         16'h0000);
    Reset_N = 1'b1;
    ack(16'h9999);
    chk("rmb_stray_i_done", {15'd0, i_done}, 16'd0);
    chk("rmb_stray_busy",   {15'd0, busy},   16'd0);
    chk("rmb_stray_rdata",  i_rdata,         16'h0000);

    // Spurious ack while idle.
    ack(16'h7777);
    chk("sp_i_done",  {15'd0, i_done}, 16'd0);
    chk("sp_d_done",  {15'd0, d_done}, 16'd0);
    chk("sp_m_req",   {15'd0, m_req},  16'd0);
    chk("sp_d_rdata", d_rdata,         16'h0000);
    step();
    chk("sp_busy", {15'd0, busy}, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
